// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin arbiter and sequencer for a shared 8:1 single-bit mux.
// Eight requesters compete for the mux. One owner is granted at a time. A tenure ends
// when the owner drops its request or after MAX_HOLD cycles. The scan then restarts
// just above the last owner, so no requester can starve the others.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   req      in   [7:0] request vector, bit i = requester i
//   d        in   [7:0] mux data inputs, bit i belongs to requester i
//   gnt      out  [7:0] registered one-hot grant, zero when idle
//   sel      out  [2:0] registered mux select (index of the granted requester)
//   y        out  d[sel] while y_valid, else 0 (combinational from sel)
//   y_valid  out  high while a grant is active
module mux8_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 4,  // 1..15
    parameter int unsigned CNT_W    = 4   // 2**CNT_W > MAX_HOLD
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] d,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       y,
    output logic       y_valid
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

    state_e             state_q, state_d;
    logic [7:0]         gnt_q, gnt_d;
    logic [2:0]         sel_q, sel_d;
    logic [2:0]         ptr_q, ptr_d;
    logic [CNT_W-1:0]   hold_q, hold_d;

    logic               rel;
    logic               win_found;
    logic [2:0]         win_idx;
    logic [2:0]         scan_idx;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        win_found = 1'b0;
        win_idx   = 3'd0;
        scan_idx  = 3'd0;

        rel = (state_q == StGrant) && (!req[sel_q] || (hold_q == HoldLast));

        // The pointer moves only on release; re-arbitration in the same edge uses the new value.
        if (rel) begin
            ptr_d = sel_q + 3'd1;
        end

        // Scan from the farthest offset down, so the closest requester to ptr_d wins last.
        for (int i = 7; i >= 0; i--) begin
            scan_idx = ptr_d + 3'(i);
            if (req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d = StGrant;
                    gnt_d   = 8'd1 << win_idx;
                    sel_d   = win_idx;
                    hold_d  = '0;
                end
            end
            StGrant: begin
                if (!rel) begin
                    hold_d = hold_q + CNT_W'(1);
                end else if (win_found) begin
                    // Back-to-back tenure, including a lone owner winning again.
                    gnt_d  = 8'd1 << win_idx;
                    sel_d  = win_idx;
                    hold_d = '0;
                end else begin
                    state_d = StIdle;
                    gnt_d   = 8'd0;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = 8'd0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            gnt_q   <= 8'd0;
            sel_q   <= 3'd0;
            ptr_q   <= 3'd0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign y_valid = (state_q == StGrant);
    assign y       = y_valid ? d[sel_q] : 1'b0;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Self-checking bench for mux8_rr_arbiter. Expected outputs per cycle are pushed to a
// queue before stimulus is applied and popped/compared after each rising edge.
// dut runs with MAX_HOLD=4, dut1 with MAX_HOLD=1; both share all inputs.
module tb_mux8_rr_arbiter;

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       y;
        logic       vld;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] d;
    logic [7:0] gnt, gnt1;
    logic [2:0] sel, sel1;
    logic       y, y1;
    logic       y_valid, y_valid1;

    int   errors;
    int   checks;
    exp_t exp_q[$];
    exp_t e;

    mux8_rr_arbiter #(.MAX_HOLD(4), .CNT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .d       (d),
        .gnt     (gnt),
        .sel     (sel),
        .y       (y),
        .y_valid (y_valid)
    );

    mux8_rr_arbiter #(.MAX_HOLD(1), .CNT_W(4)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .d       (d),
        .gnt     (gnt1),
        .sel     (sel1),
        .y       (y1),
        .y_valid (y_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        d     = 8'h00;
        step();
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    function automatic exp_t mk(input int owner, input logic [7:0] dv);
        exp_t r;
        if (owner < 0) begin
            r.gnt = 8'h00; r.sel = 3'd0; r.y = 1'b0; r.vld = 1'b0;
        end else begin
            r.gnt = 8'd1 << owner; r.sel = 3'(owner); r.y = dv[owner]; r.vld = 1'b1;
        end
        return r;
    endfunction

    task automatic test_reset();
        do_reset();
        req = 8'h04;
        d   = 8'h04;
        exp_q.push_back(mk(2, d));
        step();
        e = exp_q.pop_front();
        checks++;
        if (gnt !== e.gnt || sel !== e.sel || y !== e.y || y_valid !== e.vld) begin
            errors++;
            $display("FAIL reset_pre_grant: gnt=%h sel=%0d y=%b v=%b want gnt=%h sel=%0d y=%b v=%b",
                     gnt, sel, y, y_valid, e.gnt, e.sel, e.y, e.vld);
        end
        // Assert reset between edges; outputs must clear without a clock edge.
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 8'h00 || sel !== 3'd0 || y !== 1'b0 || y_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: gnt=%h sel=%0d y=%b v=%b want all zero",
                     gnt, sel, y, y_valid);
        end
        req = 8'h00;
        #2 rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            exp_q.push_back(mk(-1, d));
            step();
            e = exp_q.pop_front();
            checks++;
            if (gnt !== e.gnt || sel !== e.sel || y !== e.y || y_valid !== e.vld) begin
                errors++;
                $display("FAIL reset_idle cyc %0d: gnt=%h sel=%0d y=%b v=%b want all zero",
                         c, gnt, sel, y, y_valid);
            end
        end
    endtask

    task automatic test_single_request();
        logic [7:0] rq[5] = '{8'h08, 8'h08, 8'h08, 8'h00, 8'h00};
        int         own[5] = '{3, 3, 3, -1, -1};
        do_reset();
        d = 8'h08;
        for (int c = 0; c < 5; c++) exp_q.push_back(mk(own[c], d));
        for (int c = 0; c < 5; c++) begin
            req = rq[c];
            step();
            e = exp_q.pop_front();
            checks++;
            if (gnt !== e.gnt || (e.vld && sel !== e.sel) || y !== e.y || y_valid !== e.vld) begin
                errors++;
                $display("FAIL single_req cyc %0d: gnt=%h sel=%0d y=%b v=%b want gnt=%h sel=%0d y=%b v=%b",
                         c, gnt, sel, y, y_valid, e.gnt, e.sel, e.y, e.vld);
            end
            // Combinational data path: d change shows on y within the cycle.
            if (c == 1) begin
                d = 8'h00;
                #1;
                checks++;
                if (y !== 1'b0) begin
                    errors++;
                    $display("FAIL single_req_comb_y: y=%b want 0", y);
                end
                d = 8'h08;
            end
        end
    endtask

    task automatic test_full_contention();
        do_reset();
        d = 8'hA5;
        for (int c = 0; c < 36; c++) exp_q.push_back(mk((c / 4) % 8, d));
        exp_q.push_back(mk(-1, d));
        req = 8'hFF;
        for (int c = 0; c < 37; c++) begin
            if (c == 36) req = 8'h00;
            step();
            e = exp_q.pop_front();
            checks++;
            if (gnt !== e.gnt || (e.vld && sel !== e.sel) || y !== e.y || y_valid !== e.vld) begin
                errors++;
                $display("FAIL full_contention cyc %0d: gnt=%h sel=%0d y=%b v=%b want gnt=%h sel=%0d y=%b v=%b",
                         c, gnt, sel, y, y_valid, e.gnt, e.sel, e.y, e.vld);
            end
        end
    endtask

    task automatic test_wrap_around();
        // Owner 2 drops its request -> ptr=3, idle; then req=05 wraps to 0, then 2.
        logic [7:0] rq[8] = '{8'h04, 8'h00, 8'h05, 8'h05, 8'h05, 8'h05, 8'h05, 8'h00};
        int         own[8] = '{2, -1, 0, 0, 0, 0, 2, -1};
        do_reset();
        d = 8'h01;
        for (int c = 0; c < 8; c++) exp_q.push_back(mk(own[c], d));
        for (int c = 0; c < 8; c++) begin
            req = rq[c];
            step();
            e = exp_q.pop_front();
            checks++;
            if (gnt !== e.gnt || (e.vld && sel !== e.sel) || y !== e.y || y_valid !== e.vld) begin
                errors++;
                $display("FAIL wrap_around cyc %0d: gnt=%h sel=%0d y=%b v=%b want gnt=%h sel=%0d y=%b v=%b",
                         c, gnt, sel, y, y_valid, e.gnt, e.sel, e.y, e.vld);
            end
        end
    endtask

    task automatic test_lone_hog();
        // Requester 5 alone for 10 edges, then requester 0 joins. The third tenure
        // began at edge 9, so the hand-over to 0 lands exactly on edge 13.
        do_reset();
        d = 8'h20;
        for (int c = 0; c < 12; c++) exp_q.push_back(mk(5, d));
        exp_q.push_back(mk(0, d));
        for (int c = 0; c < 13; c++) begin
            req = (c < 10) ? 8'h20 : 8'h21;
            step();
            e = exp_q.pop_front();
            checks++;
            if (gnt !== e.gnt || (e.vld && sel !== e.sel) || y !== e.y || y_valid !== e.vld) begin
                errors++;
                $display("FAIL lone_hog cyc %0d: gnt=%h sel=%0d y=%b v=%b want gnt=%h sel=%0d y=%b v=%b",
                         c, gnt, sel, y, y_valid, e.gnt, e.sel, e.y, e.vld);
            end
        end
    endtask

    task automatic test_data_rotate();
        logic [7:0] yexp = 8'b1010_1101;
        do_reset();
        d = 8'b1010_1101;
        for (int c = 0; c < 9; c++) begin
            e.gnt = 8'd1 << (c % 8);
            e.sel = 3'(c % 8);
            e.y   = yexp[c % 8];
            e.vld = 1'b1;
            exp_q.push_back(e);
        end
        req = 8'hFF;
        for (int c = 0; c < 9; c++) begin
            step();
            e = exp_q.pop_front();
            checks++;
            if (gnt1 !== e.gnt || sel1 !== e.sel || y1 !== e.y || y_valid1 !== e.vld) begin
                errors++;
                $display("FAIL data_rotate cyc %0d: gnt=%h sel=%0d y=%b v=%b want gnt=%h sel=%0d y=%b v=%b",
                         c, gnt1, sel1, y1, y_valid1, e.gnt, e.sel, e.y, e.vld);
            end
        end
        req = 8'h00;
        step();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        req    = 8'h00;
        d      = 8'h00;
        #3;
        test_reset();
        test_single_request();
        test_full_contention();
        test_wrap_around();
        test_lone_hog();
        test_data_rotate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
Round-robin arbiter and sequencer for the shared 8:1 single-bit mux datapath. Eight requesters compete for the mux. The block grants one requester at a time, drives the 3-bit select, and presents the selected bit with a valid flag. Each grant lasts until the owner drops its request or a hold limit expires, so no requester can starve the others.

Parameters:
MAX_HOLD, 4, maximum consecutive cycles one grant tenure may last; legal range 1..15.
CNT_W, 4, width of the internal hold counter; must satisfy 2**CNT_W > MAX_HOLD.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  8  request vector; bit i = requester i wants the mux
d  input  8  mux data inputs; bit i belongs to requester i
gnt  output  8  one-hot grant, registered; all zero when idle
sel  output  3  registered mux select = index of granted requester
y  output  1  d[sel] while y_valid=1, else 0 (combinational from registered sel)
y_valid  output  1  high while a grant is active (state GRANT)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (async assert, sync deassert assumed by integration):
  - gnt=0, sel=0, y=0, y_valid=0.
  - state=IDLE, hold_cnt=0, rr pointer ptr=0.
  - Reset mid-grant drops everything immediately, without waiting for a clock edge.
- States: IDLE, GRANT.
- Winner selection:
  - Scan req starting at ptr upward: ptr, ptr+1, ..., 7, 0, ..., ptr-1 (mod 8).
  - The first set bit wins.
  - After reset, requester 0 has highest priority.
- IDLE:
  - If req != 0 at a rising edge: go to GRANT, load gnt/sel with the winner, hold_cnt=0.
  - Latency from req sampled high to gnt high is 1 cycle.
  - If req == 0: stay in IDLE.
- GRANT, at each rising edge:
  - Release condition: req[sel]==0 OR hold_cnt==MAX_HOLD-1.
  - No release: hold_cnt increments; gnt/sel unchanged.
  - On release: ptr <= sel+1 (mod 8); re-arbitrate in the same edge using the new ptr.
  - Re-arbitration with any req bit set: enter a new tenure immediately, with no idle gap. gnt/sel load the new winner and hold_cnt=0.
  - Re-arbitration with req == 0: go to IDLE; gnt=0, y_valid=0.
  - A current owner whose req is still high can win again only if no other requester is pending, because it is scanned last. In that case gnt stays asserted continuously and hold_cnt restarts at 0.
- Release timing: gnt remains high during the cycle in which the owner's req is first seen low; it clears at the following edge.
- Tenure length: a tenure lasts at most MAX_HOLD cycles. With MAX_HOLD=1, the grant rotates every cycle among pending requesters.
- Data path:
  - y = d[sel] when y_valid, else 0.
  - Changes on d propagate to y combinationally within the cycle.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt[sel]==1 whenever y_valid==1.
  - ptr never changes except on release.

Test Plan:
- Reset: assert rst_n=0 mid-grant (gnt=8'h04) between edges -> gnt=0, sel=0, y=0, y_valid=0 immediately; after release of reset with req=0, outputs stay 0.
- Single request: req=8'h08 for 3 cycles then 0, d=8'h08 -> gnt=8'h08, sel=3, y=1, y_valid=1 from the edge after req rises; gnt clears one edge after req falls; state returns to IDLE.
- Full contention: req=8'hFF held, MAX_HOLD=4 -> grants 0,1,2,...,7,0 in order, each exactly 4 cycles; no cycle with y_valid=0.
- Wrap-around: winner 2 releases, then req=8'h05 -> ptr=3; scan wraps, so requester 0 is granted (gnt=8'h01), then requester 2 on its release.
- Lone hog: only req[5]=1 held 10 cycles, MAX_HOLD=4 -> gnt=8'h20 continuous, y_valid never drops, hold_cnt resets every 4 cycles.
- Data check: d=8'b1010_1101, req=8'hFF, MAX_HOLD=1 -> sel steps 0..7 each cycle; y = 1,0,1,1,0,1,0,1.
